// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared widths, forward selects and FSM encoding for the hazard controller
package mips_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // $zero is hard-wired, so a write to it never produces a forwardable value.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  wr_mem,
    input logic [REG_ADDR_W-1:0] dst_mem,
    input logic                  wr_wb,
    input logic [REG_ADDR_W-1:0] dst_wb
  );
    if (wr_mem && (dst_mem != '0) && (dst_mem == src)) begin
      return FWD_MEM;
    end else if (wr_wb && (dst_wb != '0) && (dst_wb == src)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle; HAZARD_PERF_CNT_EN adds counter outputs
interface pipeline_hazard_ctrl_if;
  import mips_pipe_pkg::*;

  logic [REG_ADDR_W-1:0] rs_ID;
  logic [REG_ADDR_W-1:0] rt_ID;
  logic [REG_ADDR_W-1:0] rs_EX;
  logic [REG_ADDR_W-1:0] rt_EX;
  logic                  memRead_EX;
  logic                  pc_src_EX;
  logic                  Reg_Write_MEM;
  logic                  Reg_Write_WB;
  logic [REG_ADDR_W-1:0] Write_Reg_MEM;
  logic [REG_ADDR_W-1:0] Write_Reg_WB;
  logic                  memAccess_MEM;
  logic                  dmem_ready;

  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_write;
  logic                  idex_flush;
  logic                  exmem_write;
  logic                  memwb_bubble;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0]           lu_stall_cnt;
  logic [15:0]           flush_cnt;
  logic [15:0]           mem_wait_cnt;
`endif

  modport master (
    output rs_ID, rt_ID, rs_EX, rt_EX, memRead_EX, pc_src_EX,
           Reg_Write_MEM, Reg_Write_WB, Write_Reg_MEM, Write_Reg_WB,
           memAccess_MEM, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, memwb_bubble, fwd_a, fwd_b, mem_err
`ifdef HAZARD_PERF_CNT_EN
          ,lu_stall_cnt, flush_cnt, mem_wait_cnt
`endif
  );

  modport slave (
    input  rs_ID, rt_ID, rs_EX, rt_EX, memRead_EX, pc_src_EX,
           Reg_Write_MEM, Reg_Write_WB, Write_Reg_MEM, Write_Reg_WB,
           memAccess_MEM, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, memwb_bubble, fwd_a, fwd_b, mem_err
`ifdef HAZARD_PERF_CNT_EN
          ,lu_stall_cnt, flush_cnt, mem_wait_cnt
`endif
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// rtl/pipeline_hazard_ctrl_forward_unit.sv - combinational EX operand forward select, MEM over WB
module forward_unit
  import mips_pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs_ex_i,
  input  logic [REG_ADDR_W-1:0] rt_ex_i,
  input  logic                  reg_write_mem_i,
  input  logic [REG_ADDR_W-1:0] write_reg_mem_i,
  input  logic                  reg_write_wb_i,
  input  logic [REG_ADDR_W-1:0] write_reg_wb_i,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o
);

  assign fwd_a_o = fwd_sel(rs_ex_i, reg_write_mem_i, write_reg_mem_i,
                           reg_write_wb_i, write_reg_wb_i);
  assign fwd_b_o = fwd_sel(rt_ex_i, reg_write_mem_i, write_reg_mem_i,
                           reg_write_wb_i, write_reg_wb_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - MIPS stall/flush/forward controller with bounded dmem wait; HAZARD_PERF_CNT_EN adds perf counters
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MAX_WAIT   = 15,
  parameter int WAIT_CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_hazard_ctrl_if.slave   hz
);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  mem_err_q, mem_err_d;

  logic mem_stall, timeout, freeze, branch_flush, lu_hit, load_use;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic exmem_write, memwb_bubble;

  assign mem_stall    = hz.memAccess_MEM & ~hz.dmem_ready;
  // On the last permitted wait cycle the access is treated as complete.
  assign timeout      = (state_q == ST_MEM_WAIT) && (cnt_q == WAIT_CNT_W'(MAX_WAIT));
  assign freeze       = mem_stall & ~timeout;
  assign branch_flush = hz.pc_src_EX & ~freeze;
  assign lu_hit       = hz.memRead_EX && (hz.rt_EX != '0) &&
                        ((hz.rt_EX == hz.rs_ID) || (hz.rt_EX == hz.rt_ID));
  assign load_use     = lu_hit & ~freeze & ~hz.pc_src_EX;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_err_d    = mem_err_q;
    pc_write     = ~freeze & ~load_use;
    ifid_write   = ~freeze & ~load_use;
    ifid_flush   = branch_flush;
    idex_write   = ~freeze;
    idex_flush   = branch_flush | load_use;
    exmem_write  = ~freeze;
    memwb_bubble = freeze;

    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d = ST_MEM_WAIT;
          cnt_d   = WAIT_CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WAIT_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_write   = idex_write;
  assign hz.idex_flush   = idex_flush;
  assign hz.exmem_write  = exmem_write;
  assign hz.memwb_bubble = memwb_bubble;
  assign hz.mem_err      = mem_err_q;

  forward_unit u_forward_unit (
    .rs_ex_i         (hz.rs_EX),
    .rt_ex_i         (hz.rt_EX),
    .reg_write_mem_i (hz.Reg_Write_MEM),
    .write_reg_mem_i (hz.Write_Reg_MEM),
    .reg_write_wb_i  (hz.Reg_Write_WB),
    .write_reg_wb_i  (hz.Write_Reg_WB),
    .fwd_a_o         (hz.fwd_a),
    .fwd_b_o         (hz.fwd_b)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] lu_cnt_q, flush_cnt_q, wait_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (load_use && (lu_cnt_q != 16'hFFFF))        lu_cnt_q    <= lu_cnt_q + 16'd1;
      if (branch_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
      if (freeze && (wait_cnt_q != 16'hFFFF))        wait_cnt_q  <= wait_cnt_q + 16'd1;
    end
  end

  assign hz.lu_stall_cnt = lu_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;
  assign hz.mem_wait_cnt = wait_cnt_q;
`endif

endmodule
